// File: rtl/if_pkg.sv
`default_nettype none
// if_pkg -- shared state encoding, fetch-buffer entry layout and constants for the IF stage.
// rev 1.0
package if_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } if_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] instr;
  } fb_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// if_fetch_stage_if -- instruction-memory req/ack bus between the fetch stage and memory.
// rev 1.0
interface if_fetch_stage_if;
  import if_pkg::*;

  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [PC_W-1:0] data;

  modport master (output req, addr, input ack, data);
  modport slave  (input req, addr, output ack, data);

endinterface
`default_nettype wire

// File: rtl/if_fetch_fifo.sv
`default_nettype none
// if_fetch_fifo -- synchronous fetch buffer of {pc4, instr} entries with push/pop/flush.
// rev 1.0
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int FB_DEPTH = 2,
  localparam int AW = $clog2(FB_DEPTH)
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fb_entry_t push_data,
  output fb_entry_t head,
  output logic [AW:0] count
);

  fb_entry_t      mem [FB_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push && !flush && !pop && count == (AW+1)'(FB_DEPTH)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(pop && !flush && count == '0));

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// if_fetch_stage -- PC, variable-latency fetch FSM, fetch buffer and IF/ID register.
// Optional IF_PERF_CNT_EN adds stall-cycle and flush counters.  rev 1.0
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0,
  parameter int              FB_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] branch_target_i,
  if_fetch_stage_if.master imem,
  output logic [PC_W-1:0] if_id_instr_o,
  output logic [PC_W-1:0] if_id_pc4_o,
  output logic            if_id_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cyc_o,
  output logic [31:0]     perf_flush_cnt_o
`endif
);

  localparam int          AW      = $clog2(FB_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FB_DEPTH);

  if_state_t       state;
  if_state_t       state_nx;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] discard_addr;
  logic [AW:0]     fb_count;
  logic [AW:0]     level_nx;
  fb_entry_t       fb_head;
  fb_entry_t       fb_in;
  logic            fetch_req;
  logic            ack;
  logic            push;
  logic            pop;
  logic            space;

  assign ack      = fetch_req && imem.ack;
  assign pop      = !flush_i && !stall_i && (fb_count != '0);
  assign push     = ack && (state == REQ) && !flush_i;
  assign level_nx = fb_count + (AW+1)'(push) - (AW+1)'(pop);
  // A flush empties the buffer, so there is always room afterwards.
  assign space    = flush_i || (level_nx < DEPTH_L);
  assign fb_in    = {pc + 32'd4, imem.data};

  assign imem.req  = fetch_req;
  assign imem.addr = (state == DISCARD) ? discard_addr : pc;

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    fetch_req = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nx = space ? REQ : HOLD;
      end
      REQ: begin
        fetch_req = 1'b1;
        if (imem.ack) begin
          pc_nx    = pc + 32'd4;
          state_nx = !start_i ? IDLE : (space ? REQ : HOLD);
        end else if (flush_i) begin
          state_nx = DISCARD;
        end
      end
      HOLD: begin
        if (!start_i)  state_nx = IDLE;
        else if (space) state_nx = REQ;
      end
      DISCARD: begin
        fetch_req = 1'b1;
        if (imem.ack) state_nx = !start_i ? IDLE : (space ? REQ : HOLD);
      end
      default: state_nx = IDLE;
    endcase
    if (flush_i) pc_nx = branch_target_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      discard_addr <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      // The abandoned request keeps its address on the bus until memory answers.
      if (state == REQ && state_nx == DISCARD) discard_addr <= pc;
    end
  end

  if_fetch_fifo #(.FB_DEPTH(FB_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .pop       (pop),
    .flush     (flush_i),
    .push_data (fb_in),
    .head      (fb_head),
    .count     (fb_count)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_id_instr_o <= NOP_INSTR;
      if_id_pc4_o   <= '0;
      if_id_valid_o <= 1'b0;
    end else if (flush_i || (!stall_i && fb_count == '0)) begin
      if_id_instr_o <= NOP_INSTR;
      if_id_pc4_o   <= '0;
      if_id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if_id_instr_o <= fb_head.instr;
      if_id_pc4_o   <= fb_head.pc4;
      if_id_valid_o <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_stall_cyc_o <= '0;
      perf_flush_cnt_o <= '0;
    end else if (start_i) begin
      if (stall_i && !flush_i) perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
      if (flush_i)             perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
